// File: rtl/loader_sequencer.sv
// Host-side sequencer for the matrix data loader: takes a job descriptor,
// streams clear/dims/data to the loader, drains, then holds the product.
module loader_sequencer #(
  parameter int unsigned CTRL_DELAY = 1,
  parameter int unsigned MULT_LAT   = 2,
  parameter int unsigned MAX_ELEM   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_dims,
  output logic        cmd_err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [7:0]  ld_data,
  output logic [1:0]  ld_ctrl,
  input  logic [63:0] res_mat,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_out,
  output logic        busy
);

  // Drain counter runs 0..DrainLen inclusive, so the capture lands one cycle after
  // the loader's multiply latency has elapsed from the last data code at ld_ctrl.
  localparam int unsigned DrainLen = CTRL_DELAY + MULT_LAT;
  localparam int unsigned DrainW   = $clog2(DrainLen + 1);
  localparam logic [7:0]  MaxElem  = 8'(MAX_ELEM);

  localparam logic [1:0] CodeData  = 2'd0;
  localparam logic [1:0] CodeDim   = 2'd1;
  localparam logic [1:0] CodeClear = 2'd2;
  localparam logic [1:0] CodeIdle  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StDims,
    StData,
    StDrain,
    StResult
  } state_e;

  state_e                     state_q, state_d;
  logic [15:0]                dims_q, dims_d;
  logic [1:0]                 dim_idx_q, dim_idx_d;
  logic [3:0]                 elem_cnt_q, elem_cnt_d;
  logic [3:0]                 total_q, total_d;
  logic [DrainW-1:0]          drain_cnt_q, drain_cnt_d;
  logic [7:0]                 ld_data_q, ld_data_d;
  logic [1:0]                 code_q, code_d;
  logic [CTRL_DELAY-1:0][1:0] ctrl_dly_q, ctrl_dly_d;
  logic                       cmd_err_q, cmd_err_d;
  logic [63:0]                res_out_q, res_out_d;

  logic [3:0] r1, c1, r2, c2;
  logic [7:0] prod_a, prod_b;
  logic       cmd_bad;

  // Decode the offered descriptor and flag any shape the loader cannot take.
  always_comb begin
    r1      = cmd_dims[15:12];
    c1      = cmd_dims[11:8];
    r2      = cmd_dims[7:4];
    c2      = cmd_dims[3:0];
    prod_a  = {4'h0, r1} * {4'h0, c1};
    prod_b  = {4'h0, r2} * {4'h0, c2};
    cmd_bad = (r1 == 4'h0) || (c1 == 4'h0) || (r2 == 4'h0) || (c2 == 4'h0) ||
              (c1 != r2) || (prod_a > MaxElem) || (prod_b > MaxElem);
  end

  // Next-state, raw loader code and handshake outputs.
  always_comb begin
    state_d     = state_q;
    dims_d      = dims_q;
    dim_idx_d   = dim_idx_q;
    elem_cnt_d  = elem_cnt_q;
    total_d     = total_q;
    drain_cnt_d = drain_cnt_q;
    ld_data_d   = ld_data_q;
    code_d      = CodeIdle;
    cmd_err_d   = 1'b0;
    res_out_d   = res_out_q;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_bad) begin
            cmd_err_d = 1'b1;
          end else begin
            dims_d  = cmd_dims;
            total_d = prod_a[3:0] + prod_b[3:0];
            state_d = StClear;
          end
        end
      end
      StClear: begin
        code_d    = CodeClear;
        ld_data_d = 8'h00;
        dim_idx_d = 2'd0;
        state_d   = StDims;
      end
      StDims: begin
        code_d = CodeDim;
        unique case (dim_idx_q)
          2'd0: ld_data_d = {4'h0, dims_q[15:12]};
          2'd1: ld_data_d = {4'h0, dims_q[11:8]};
          2'd2: ld_data_d = {4'h0, dims_q[7:4]};
          2'd3: ld_data_d = {4'h0, dims_q[3:0]};
          default: ld_data_d = 8'h00;
        endcase
        dim_idx_d = dim_idx_q + 2'd1;
        if (dim_idx_q == 2'd3) begin
          elem_cnt_d = 4'h0;
          state_d    = StData;
        end
      end
      StData: begin
        in_ready = 1'b1;
        // A stall keeps the idle code so the loader never counts a phantom element.
        if (in_valid) begin
          ld_data_d  = in_data;
          code_d     = CodeData;
          elem_cnt_d = elem_cnt_q + 4'd1;
          if (elem_cnt_q + 4'd1 == total_q) begin
            drain_cnt_d = '0;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DrainW'(DrainLen)) begin
          res_out_d = res_mat;
          state_d   = StResult;
        end
      end
      StResult: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control code delay line: aligns each code with the loader's registered byte.
  always_comb begin
    ctrl_dly_d    = ctrl_dly_q;
    ctrl_dly_d[0] = code_q;
    for (int i = 1; i < int'(CTRL_DELAY); i++) begin
      ctrl_dly_d[i] = ctrl_dly_q[i-1];
    end
  end

  // State and output registers; reset parks the loader bus on the idle code.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      dims_q      <= 16'h0000;
      dim_idx_q   <= 2'd0;
      elem_cnt_q  <= 4'h0;
      total_q     <= 4'h0;
      drain_cnt_q <= '0;
      ld_data_q   <= 8'h00;
      code_q      <= CodeIdle;
      ctrl_dly_q  <= '1;
      cmd_err_q   <= 1'b0;
      res_out_q   <= 64'h0;
    end else begin
      state_q     <= state_d;
      dims_q      <= dims_d;
      dim_idx_q   <= dim_idx_d;
      elem_cnt_q  <= elem_cnt_d;
      total_q     <= total_d;
      drain_cnt_q <= drain_cnt_d;
      ld_data_q   <= ld_data_d;
      code_q      <= code_d;
      ctrl_dly_q  <= ctrl_dly_d;
      cmd_err_q   <= cmd_err_d;
      res_out_q   <= res_out_d;
    end
  end

  assign ld_data   = ld_data_q;
  assign ld_ctrl   = ctrl_dly_q[CTRL_DELAY-1];
  assign cmd_err   = cmd_err_q;
  assign res_out   = res_out_q;
  assign res_valid = (state_q == StResult);
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/loader_sequencer.md
Name: loader_sequencer

Overview:
- Host-side controller for the matrix data loader.
- Accepts a job descriptor (four dimension nibbles) over a valid/ready handshake, then a byte stream of matrix elements.
- Drives the loader's byte bus and 2-bit control code in the required order: clear, dims, data.
- Waits a fixed drain latency, captures the 64-bit product and holds it until the host takes it.

Parameters:
- CTRL_DELAY, 1: cycles ld_ctrl lags ld_data; matches the loader's input data flop.
- MULT_LAT, 2: cycles from last data control to a valid res_mat.
- MAX_ELEM, 4: maximum elements per operand matrix.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  descriptor accepted when high with cmd_valid.
- cmd_dims  in  16  {R1,C1,R2,C2}, 4 bits each, R1 in [15:12].
- cmd_err  out  1  one-cycle pulse: descriptor rejected.
- in_valid  in  1  element byte valid.
- in_ready  out  1  element byte accepted.
- in_data  in  8  element byte.
- ld_data  out  8  byte to loader.
- ld_ctrl  out  2  loader code: 0 = data, 1 = dim, 2 = clear, 3 = idle.
- res_mat  in  64  loader product.
- res_valid  out  1  result held.
- res_ready  in  1  host takes result.
- res_out  out  64  captured product.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async): state IDLE; cmd_ready=1, in_ready=0, cmd_err=0, res_valid=0, res_out=0, ld_data=0, busy=0.
- Reset also sets every ld_ctrl delay stage to 3, so ld_ctrl=3 immediately.
- ld_data is registered. The raw control code is registered, then passes CTRL_DELAY further flop stages before reaching ld_ctrl. Each byte's code therefore appears CTRL_DELAY cycles after the byte.
- States: IDLE, CLEAR, DIMS, DATA, DRAIN, RESULT.
- IDLE: cmd_ready=1 (combinational on state).
  - Handshake with a valid descriptor: latch dims; next state CLEAR.
  - Invalid descriptor: any field 0, C1 != R2, R1*C1 > MAX_ELEM, or R2*C2 > MAX_ELEM. Accept it, pulse cmd_err the next cycle, stay IDLE.
- CLEAR: one cycle; raw code 2, ld_data=0; next state DIMS.
- DIMS: four cycles, dim_idx 0..3; raw code 1; ld_data={4'h0, field}, order R1, C1, R2, C2. At dim_idx 3, next state DATA.
- DATA: total = R1*C1 + R2*C2 (4-bit, max 8); elem_cnt starts at 0; in_ready=1.
  - Transfer cycle: ld_data=in_data, raw code 0, elem_cnt++.
  - No transfer (in_valid=0): raw code 3, ld_data holds. A stall must never emit code 0.
  - Transfer bringing elem_cnt to total: in_ready drops next cycle; next state DRAIN.
- DRAIN: counter runs CTRL_DELAY + MULT_LAT cycles, raw code 3. On the final cycle res_out<=res_mat; next state RESULT.
- RESULT: res_valid=1; res_out stable.
  - res_ready high: res_valid clears next edge; next state IDLE.
  - res_ready may already be high on entry: one-cycle hold, then IDLE.
- cmd_ready is 0 in every non-IDLE state. A descriptor offered mid-job waits and is not lost. cmd_err never fires outside IDLE.
- Every job starts with CLEAR. The loader has no reset, so no stale count survives between jobs.
- RST mid-job: immediate return to IDLE. Partial loader contents are discarded; the next job's CLEAR recovers the loader.
- No cycle may issue codes 0, 1 and 2 in the same cycle. Exactly one code per cycle at ld_ctrl.

Test Plan:
- Reset, then idle 5 cycles -> ld_ctrl=3, ld_data=0, cmd_ready=1, busy=0, res_valid=0 throughout.
- Dims 16'h2112 (2x1 by 1x2), in_valid held high, bytes 01,02,03,04 -> ld_data sequence 00, 02, 01, 01, 02, 01, 02, 03, 04. ld_ctrl sequence 2, 1, 1, 1, 1, 0, 0, 0, 0, lagging ld_data by 1 cycle. res_valid asserted exactly 3 cycles after the last ld_ctrl=0; res_out equals res_mat sampled on the last DRAIN cycle.
- Same job with in_valid low 2 cycles between bytes 2 and 3 -> ld_ctrl=3 during the gap; no extra data code; element count still 4.
- Dims 16'h2132 (C1 != R2), then 16'h3311 (R1*C1 = 9 > 4), then 16'h0111 (zero field) -> cmd_err pulses once per descriptor; state stays IDLE; ld_ctrl stays 3.
- res_ready held low 10 cycles in RESULT, with a second descriptor offered -> res_valid and res_out stable, cmd_ready=0. res_ready=1 -> IDLE next cycle; second descriptor accepted the following cycle.
- RST pulsed during DATA after 1 byte -> outputs return to reset values immediately. The next 16'h2112 job completes normally, starting with ld_ctrl=2.
